clint: RTL and testbench
========================

// Module: clint
// PURPOSE
//  Core-local interrupt/trap sequencer. Feeds hold_flag_clint_i of the pipeline controller.
//  Detects ecall/ebreak/mret in decode and enabled async interrupts, stalls the pipeline,
//  writes mepc/mcause/mstatus via the CSR write port, then redirects the PC to the handler or to mepc.
// PARAMETERS
//  INT_W      8      width of int_flag_i; bit0 = timer, bits[INT_W-1:1] = external
// PORTS
//  clk             in   1    core clock
//  rstn            in   1    synchronous reset, active low
//  int_flag_i      in   INT_W  level interrupt requests from peripherals
//  inst_i          in   32   instruction in decode
//  inst_addr_i     in   32   PC of inst_i
//  jump_flag_i     in   1    exu branch/jump taken this cycle
//  jump_addr_i     in   32   exu jump target
//  div_started_i   in   1    divider busy; async entry deferred while high
//  csr_mtvec_i     in   32   current mtvec
//  csr_mepc_i      in   32   current mepc
//  csr_mstatus_i   in   32   current mstatus (MIE=bit3, MPIE=bit7)
//  hold_flag_o     out  1    stall request to controller
//  we_o            out  1    CSR write enable
//  waddr_o         out  12   CSR address (0x341 mepc, 0x342 mcause, 0x300 mstatus)
//  data_o          out  32   CSR write data
//  int_assert_o    out  1    one-cycle redirect strobe to PC
//  int_addr_o      out  32   redirect target
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): FSM->IDLE; we_o, waddr_o, data_o, int_assert_o, int_addr_o = 0.
//    Reset mid-sequence abandons it; no further CSR writes issued.
//  - Request classify (comb., IDLE only), priority: SYNC (inst_i==ECALL 0x00000073 | EBREAK
//    0x00100073) > MRET (0x30200073) > ASYNC (|int_flag_i & MIE & ~div_started_i).
//  - hold_flag_o = (state!=IDLE) | (request!=NONE); combinational.
//  - FSM: IDLE -> MEPC -> MCAUSE -> MSTATUS -> IDLE (trap); IDLE -> MRET -> IDLE.
//    Entry into MEPC/MRET latches cause and return PC on the request cycle.
//  - Return PC: SYNC -> inst_addr_i; ASYNC -> jump_flag_i ? jump_addr_i : inst_addr_i.
//  - Cause: ecall 11, ebreak 3; ASYNC int_flag_i[0] -> 0x80000007, else 0x8000000B.
//  - Each write state drives we_o=1 with its addr/data for exactly one cycle (registered outputs):
//    MEPC: data=ret PC; MCAUSE: data=cause; MSTATUS: MPIE<=MIE, MIE<=0, other bits kept.
//    MRET: mstatus MIE<=MPIE, MPIE<=1.
//  - Redirect: int_assert_o=1 for one cycle, registered on leaving MSTATUS (target = trap vector)
//    or MRET (target = csr_mepc_i). int_addr_o holds last value otherwise.
//  - Latency: trap request -> int_assert_o = 4 cycles; mret -> 2 cycles.
//  - Requests arriving while state!=IDLE are ignored; level interrupts re-evaluated on return
//    to IDLE (MIE then 0, so no re-entry until mret).
//  - int_flag_i deasserting mid-sequence does not abort the sequence.
// CONFIGURATION
//  CLINT_VECTORED_EN defined: if csr_mtvec_i[1:0]==2'b01 and cause is async, target =
//    {mtvec[31:2],2'b00} + 4*cause[4:0]; sync traps use base.
//  Undefined: target = {mtvec[31:2],2'b00} always (direct mode).
// STRUCTURE
//  define.v: InstAddrBus, CSR addresses, ECALL/EBREAK/MRET encodings, cause codes, FSM state codes.
//  Single module; no sub-module (FSM + output regs only).
// TESTING
//  - ecall at PC 0x100, mtvec=0x200 -> mepc=0x100, mcause=11, MIE cleared, int_assert_o with 0x200 at +4.
//  - MIE=1, int_flag_i=0x01 in same cycle as jump to 0x80 -> mepc=0x80, mcause=0x80000007.
//  - mret with mepc=0x104, MPIE=1 -> mstatus MIE=1, MPIE=1; int_addr_o=0x104 at +2.
//  - div_started_i=1 with int_flag_i=0x02 -> no hold; entry once div_started_i falls.
//  - CLINT_VECTORED_EN, mtvec=0x201, external int -> int_addr_o=0x22C; without macro 0x200.
//  - rstn low during MCAUSE -> all outputs 0 next cycle, no MSTATUS write, hold_flag_o=0.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared constants, state/request types and mstatus helpers for the clint trap sequencer.
package clint_pkg;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MCAUSE,
        S_MSTATUS,
        S_MRET
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_SYNC,
        REQ_MRET,
        REQ_ASYNC
    } req_t;

    // Trap entry: stash MIE into MPIE and mask further interrupts.
    function automatic logic [31:0] mstatus_trap(input logic [31:0] m);
        logic [31:0] r;
        r           = m;
        r[MPIE_BIT] = m[MIE_BIT];
        r[MIE_BIT]  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_mret(input logic [31:0] m);
        logic [31:0] r;
        r           = m;
        r[MIE_BIT]  = m[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// CSR write port, PC redirect and stall request driven by clint toward the core.
interface clint_if;
    logic        hold_flag_o;
    logic        we_o;
    logic [11:0] waddr_o;
    logic [31:0] data_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    modport master (
        output hold_flag_o,
        output we_o,
        output waddr_o,
        output data_o,
        output int_assert_o,
        output int_addr_o
    );

    modport slave (
        input hold_flag_o,
        input we_o,
        input waddr_o,
        input data_o,
        input int_assert_o,
        input int_addr_o
    );
endinterface

// File: rtl/clint.sv
// Core-local trap/interrupt sequencer: stalls, writes mepc/mcause/mstatus, then redirects the PC.
// Optional CLINT_VECTORED_EN selects vectored targets for async causes when mtvec mode is 1.
module clint
    import clint_pkg::*;
#(
    parameter int INT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             div_started_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    clint_if.master          bus
);

    state_t      state_reg;
    req_t        req;
    logic [31:0] cause_reg;
    logic [31:0] cause_next;
    logic [31:0] ret_pc_next;
    logic [31:0] trap_target;
    logic [31:0] mtvec_base;

    logic        we_reg;
    logic [11:0] waddr_reg;
    logic [31:0] data_reg;
    logic        int_assert_reg;
    logic [31:0] int_addr_reg;

    // Requests are only recognised while idle; anything arriving mid-sequence is dropped.
    always_comb begin
        req = REQ_NONE;
        if (state_reg == S_IDLE) begin
            if (inst_i == INST_ECALL || inst_i == INST_EBREAK) begin
                req = REQ_SYNC;
            end else if (inst_i == INST_MRET) begin
                req = REQ_MRET;
            end else if ((|int_flag_i) && csr_mstatus_i[MIE_BIT] && !div_started_i) begin
                req = REQ_ASYNC;
            end
        end
    end

    always_comb begin
        cause_next = '0;
        if (req == REQ_SYNC) begin
            cause_next = (inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
        end else if (req == REQ_ASYNC) begin
            cause_next = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
        end
    end

    // An interrupt taken alongside a taken jump must resume at the jump target.
    assign ret_pc_next = (req == REQ_ASYNC && jump_flag_i) ? jump_addr_i : inst_addr_i;

    assign mtvec_base = csr_mtvec_i & ~32'h3;

    always_comb begin
        trap_target = mtvec_base;
`ifdef CLINT_VECTORED_EN
        if (csr_mtvec_i[1:0] == 2'b01 && cause_reg[31]) begin
            trap_target = mtvec_base + {25'd0, cause_reg[4:0], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= S_IDLE;
            cause_reg      <= '0;
            we_reg         <= 1'b0;
            waddr_reg      <= '0;
            data_reg       <= '0;
            int_assert_reg <= 1'b0;
            int_addr_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    we_reg         <= 1'b0;
                    int_assert_reg <= 1'b0;
                    case (req)
                        REQ_SYNC, REQ_ASYNC: begin
                            state_reg <= S_MEPC;
                            cause_reg <= cause_next;
                            we_reg    <= 1'b1;
                            waddr_reg <= CSR_MEPC;
                            data_reg  <= ret_pc_next;
                        end
                        REQ_MRET: begin
                            state_reg <= S_MRET;
                            we_reg    <= 1'b1;
                            waddr_reg <= CSR_MSTATUS;
                            data_reg  <= mstatus_mret(csr_mstatus_i);
                        end
                        default: ;
                    endcase
                end
                S_MEPC: begin
                    state_reg <= S_MCAUSE;
                    we_reg    <= 1'b1;
                    waddr_reg <= CSR_MCAUSE;
                    data_reg  <= cause_reg;
                end
                S_MCAUSE: begin
                    state_reg <= S_MSTATUS;
                    we_reg    <= 1'b1;
                    waddr_reg <= CSR_MSTATUS;
                    data_reg  <= mstatus_trap(csr_mstatus_i);
                end
                S_MSTATUS: begin
                    state_reg      <= S_IDLE;
                    we_reg         <= 1'b0;
                    int_assert_reg <= 1'b1;
                    int_addr_reg   <= trap_target;
                end
                S_MRET: begin
                    state_reg      <= S_IDLE;
                    we_reg         <= 1'b0;
                    int_assert_reg <= 1'b1;
                    int_addr_reg   <= csr_mepc_i;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    we_reg         <= 1'b0;
                    int_assert_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hold_flag_o  = (state_reg != S_IDLE) || (req != REQ_NONE);
    assign bus.we_o         = we_reg;
    assign bus.waddr_o      = waddr_reg;
    assign bus.data_o       = data_reg;
    assign bus.int_assert_o = int_assert_reg;
    assign bus.int_addr_o   = int_addr_reg;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: stimulus pushes expected CSR writes/redirects, a negedge monitor checks them.
module tb_clint;
    import clint_pkg::*;

    logic        clk;
    logic        rstn;
    logic [7:0]  int_flag;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        div_started;
    logic [31:0] mtvec;
    logic [31:0] mepc_csr;
    logic [31:0] mstatus_csr;
    logic        ld;
    logic [31:0] ld_mstatus;
    logic [31:0] ld_mepc;
    int          cyc;
    int          tests;
    int          fails;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef CLINT_VECTORED_EN
    localparam logic [31:0] EXT_VEC_TARGET = 32'h0000_022C;
`else
    localparam logic [31:0] EXT_VEC_TARGET = 32'h0000_0200;
`endif

    typedef struct {
        bit          redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          at;
    } ev_t;

    ev_t exp_q[$];

    clint_if bus();

    clint #(.INT_W(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .int_flag_i    (int_flag),
        .inst_i        (inst),
        .inst_addr_i   (inst_addr),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .div_started_i (div_started),
        .csr_mtvec_i   (mtvec),
        .csr_mepc_i    (mepc_csr),
        .csr_mstatus_i (mstatus_csr),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Small CSR file fed by the DUT's write port, with a bench-side preload path.
    always @(posedge clk) begin
        if (ld) begin
            mstatus_csr <= ld_mstatus;
            mepc_csr    <= ld_mepc;
        end else if (bus.we_o) begin
            if (bus.waddr_o == CSR_MSTATUS) mstatus_csr <= bus.data_o;
            if (bus.waddr_o == CSR_MEPC)    mepc_csr    <= bus.data_o;
        end
    end

    always @(negedge clk) begin
        if (bus.we_o || bus.int_assert_o) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: we=%0b addr=%h data=%h redir=%0b addr=%h cyc=%0d, required none",
                         bus.we_o, bus.waddr_o, bus.data_o, bus.int_assert_o, bus.int_addr_o, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.redir) begin
                    if (!bus.int_assert_o || bus.we_o || bus.int_addr_o !== e.data || cyc != e.at) begin
                        fails++;
                        $display("FAIL redirect: got assert=%0b we=%0b addr=%h cyc=%0d, required addr=%h cyc=%0d",
                                 bus.int_assert_o, bus.we_o, bus.int_addr_o, cyc, e.data, e.at);
                    end else begin
                        $display("[TB] redirect -> %h at cyc %0d", bus.int_addr_o, cyc);
                    end
                end else begin
                    if (!bus.we_o || bus.int_assert_o || bus.waddr_o !== e.addr ||
                        bus.data_o !== e.data || cyc != e.at) begin
                        fails++;
                        $display("FAIL csr_write: got we=%0b assert=%0b addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                                 bus.we_o, bus.int_assert_o, bus.waddr_o, bus.data_o, cyc, e.addr, e.data, e.at);
                    end else begin
                        $display("[TB] csr write %h <= %h at cyc %0d", bus.waddr_o, bus.data_o, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic load(input logic [31:0] ms, input logic [31:0] ep);
        ld         = 1'b1;
        ld_mstatus = ms;
        ld_mepc    = ep;
        step();
        ld         = 1'b0;
    endtask

    task automatic push_csr(input logic [11:0] a, input logic [31:0] d, input int at);
        ev_t e;
        e.redir = 1'b0; e.addr = a; e.data = d; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic push_redir(input logic [31:0] d, input int at);
        ev_t e;
        e.redir = 1'b1; e.addr = '0; e.data = d; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic push_trap(input int c, input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] ms_after, input logic [31:0] target);
        push_csr(CSR_MEPC, pc, c + 1);
        push_csr(CSR_MCAUSE, cause, c + 2);
        push_csr(CSR_MSTATUS, ms_after, c + 3);
        push_redir(target, c + 4);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},       {31'd0, bus.we_o}, 32'd0);
        check({tag, "_waddr"},    {20'd0, bus.waddr_o}, 32'd0);
        check({tag, "_data"},     bus.data_o, 32'd0);
        check({tag, "_assert"},   {31'd0, bus.int_assert_o}, 32'd0);
        check({tag, "_int_addr"}, bus.int_addr_o, 32'd0);
        check({tag, "_hold"},     {31'd0, bus.hold_flag_o}, 32'd0);
    endtask

    initial begin
        int c;
        cyc = 0; tests = 0; fails = 0;
        rstn = 1'b0; int_flag = '0; inst = NOP; inst_addr = 32'h40;
        jump_flag = 1'b0; jump_addr = '0; div_started = 1'b0; mtvec = 32'h200;
        ld = 1'b1; ld_mstatus = 32'h0; ld_mepc = 32'h0;
        step();
        ld = 1'b0;
        step();
        check_idle_outputs("reset");
        rstn = 1'b1;

        // ecall at 0x100: mepc, mcause 11, MIE cleared, redirect to 0x200 four cycles later
        load(32'h8, 32'h0);
        inst = INST_ECALL; inst_addr = 32'h100;
        c = cyc;
        push_trap(c, 32'h100, 32'd11, 32'h80, 32'h200);
        #1 check("ecall_hold_req", {31'd0, bus.hold_flag_o}, 32'd1);
        step(); inst = NOP;
        #1 check("ecall_hold_busy", {31'd0, bus.hold_flag_o}, 32'd1);
        step(); step(); step();
        #1 check("ecall_hold_done", {31'd0, bus.hold_flag_o}, 32'd0);

        // ebreak; an mret showing up while busy must be ignored
        inst = INST_EBREAK; inst_addr = 32'h140;
        c = cyc;
        push_trap(c, 32'h140, 32'd3, 32'h0, 32'h200);
        step(); inst = INST_MRET;
        step();
        #1 check("busy_mret_hold", {31'd0, bus.hold_flag_o}, 32'd1);
        step(); inst = NOP;
        step();

        // mret with mepc=0x104, MPIE=1
        load(32'h80, 32'h104);
        inst = INST_MRET;
        c = cyc;
        push_csr(CSR_MSTATUS, 32'h88, c + 1);
        push_redir(32'h104, c + 2);
        step(); inst = NOP;
        step();
        #1 check("mret_hold_done", {31'd0, bus.hold_flag_o}, 32'd0);

        // timer interrupt while a jump to 0x80 is taken; request drops mid-sequence
        load(32'h88, 32'h0);
        int_flag = 8'h01; jump_flag = 1'b1; jump_addr = 32'h80; inst_addr = 32'h50;
        c = cyc;
        push_trap(c, 32'h80, 32'h8000_0007, 32'h80, 32'h200);
        step(); int_flag = '0; jump_flag = 1'b0;
        step(); step(); step();

        // sync beats a pending interrupt; return PC ignores the jump
        load(32'h8, 32'h0);
        int_flag = 8'h01; jump_flag = 1'b1; jump_addr = 32'h300;
        inst = INST_ECALL; inst_addr = 32'h180;
        c = cyc;
        push_trap(c, 32'h180, 32'd11, 32'h80, 32'h200);
        step(); int_flag = '0; jump_flag = 1'b0; inst = NOP;
        step(); step(); step();

        // external interrupt deferred by the divider; vector mode on mtvec
        mtvec = 32'h201;
        load(32'h8, 32'h0);
        int_flag = 8'h02; div_started = 1'b1; inst_addr = 32'h60;
        for (int i = 0; i < 3; i++) begin
            #1 check("div_defer_hold", {31'd0, bus.hold_flag_o}, 32'd0);
            step();
        end
        div_started = 1'b0;
        c = cyc;
        push_trap(c, 32'h60, 32'h8000_000B, 32'h80, EXT_VEC_TARGET);
        #1 check("div_release_hold", {31'd0, bus.hold_flag_o}, 32'd1);
        step(); int_flag = '0;
        step(); step(); step();
        mtvec = 32'h200;

        // reset while in MCAUSE abandons the sequence
        load(32'h8, 32'h0);
        inst = INST_ECALL; inst_addr = 32'h1C0;
        c = cyc;
        push_csr(CSR_MEPC, 32'h1C0, c + 1);
        push_csr(CSR_MCAUSE, 32'd11, c + 2);
        step(); inst = NOP;
        step(); rstn = 1'b0;
        step();
        check_idle_outputs("mid_reset");
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("mid_reset_no_mstatus_wr", mstatus_csr, 32'h8);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
